pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the pipelined CPU fetch stage; successor to the plain 32-bit load/increment PC counter. Produces the fetch address each cycle from a prioritised choice of trap vector, execute-stage redirect, return-address-stack prediction, stall hold, or sequential step. An optional return address stack (RAS) predicts return targets at decode.

## Interface
- WIDTH, 32: PC width in bits.
- STEP, 4: sequential increment; power of two, 1 to 16.
- RESET_VEC, 0: PC value on reset.
- TRAP_VEC, 'h80: PC target on trap.
- RAS_DEPTH, 4: RAS entries; power of two, 2 to 16.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC; decode-stage push/pop are ignored.
- trap  in  1  redirect to TRAP_VEC.
- redir_valid  in  1  execute-stage branch/jump taken.
- redir_target  in  WIDTH  redirect address.
- ras_push  in  1  decode saw a call; push ras_push_addr.
- ras_push_addr  in  WIDTH  return address to push.
- ras_pop  in  1  decode saw a return; predict from the top of the stack.
- pc  out  WIDTH  current fetch address.
- pc_plus  out  WIDTH  pc + STEP, combinational.
- redirected  out  1  pc came from a non-sequential source this cycle.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_underflow  out  1  one-cycle pulse: pop on an empty stack.

## Operation
- Next-PC priority, highest first:
  - trap → TRAP_VEC
  - redir_valid → redir_target
  - ras_pop with ras_count>0 → top of stack
  - stall → pc (hold)
  - otherwise → pc + STEP
- Redirects and traps override stall.
- Alignment: the low $clog2(STEP) bits of redir_target and of RAS targets are forced to zero. TRAP_VEC and RESET_VEC must already be aligned.
- Arithmetic is modulo 2^WIDTH. pc = all-ones minus STEP+1 steps to 0, with no flag.
- RAS updates are gated:
  - When trap or redir_valid is asserted, push and pop are discarded, because decode was on the wrong path.
  - When stall is asserted, push and pop are discarded, because decode will re-present the instruction.
- RAS push:
  - Writes ras_push_addr to the top; ras_count increments.
  - When full, overwrites the oldest entry circularly; ras_count saturates at RAS_DEPTH.
- RAS pop:
  - Next pc = top entry; ras_count decrements.
  - When empty: no redirect, sequential step taken, ras_underflow pulses.
- Simultaneous push and pop: pc = old top. The top entry is replaced by ras_push_addr and ras_count is unchanged.
- redirected = 1 when the next pc came from trap, redir, or RAS. It is 0 for hold and step.

## Timing
- Reset values while rst=0 and after release:
  - pc = RESET_VEC
  - redirected = 0
  - ras_underflow = 0
  - ras_count = 0
  - RAS contents undefined
- Reset asserted mid-operation clears state immediately (asynchronous). The first post-reset edge with no stall gives pc = RESET_VEC+STEP.
- All inputs are sampled on the rising clk edge. The selected pc appears one cycle later; redirected and ras_underflow are registered alongside it.
- pc_plus follows pc combinationally in the same cycle.
- No handshake; every input is a single-cycle level qualified by its clock edge.

## Configuration
- RAS is compiled in when PC_GEN_RAS_EN is defined.
- Without PC_GEN_RAS_EN:
  - ras_push, ras_push_addr and ras_pop are ignored.
  - ras_count is tied to 0 and ras_underflow to 0.
  - Priority reduces to trap > redir > stall > step.
  - No RAS storage is inferred.

## Structure
- pc_gen_pkg holds:
  - enum pc_src_e {SRC_STEP, SRC_HOLD, SRC_RAS, SRC_REDIR, SRC_TRAP}
  - default vector constants for RESET_VEC and TRAP_VEC
- Sub-module pc_ras is a circular stack with top pointer, count, push/pop/replace and underflow logic.
- pc_ras is instantiated only under PC_GEN_RAS_EN.
- pc_gen holds the source selector, alignment masking and PC register.

## Test plan
- Reset, then release with no inputs:
  - pc = 0, then 4, then 8.
  - Assert stall 3 cycles: pc holds 8, redirected = 0.
- Stall together with redir_valid, redir_target = 'h1003:
  - Next pc = 'h1000, redirected = 1 for one cycle.
- trap together with redir_valid and ras_pop in the same cycle:
  - pc = 'h80.
  - ras_count unchanged.
- RAS_DEPTH=4, no stall:
  - Push 'h10, 'h20, 'h30, 'h40, 'h50: ras_count = 4.
  - Pop ×4: pc = 'h50, 'h40, 'h30, 'h20.
  - Fifth pop: sequential step, ras_underflow = 1.
- Simultaneous push 'h200 and pop with top 'h100:
  - pc = 'h100.
  - Next pop gives 'h200; ras_count unchanged by the combined operation.
- pc = 'hFFFF_FFFC, no stall:
  - Next pc = 0.
- Assert rst mid-stream:
  - pc = 0 immediately, ras_count = 0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the fetch-stage program-counter generator.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    SRC_STEP  = 3'd0,
    SRC_HOLD  = 3'd1,
    SRC_RAS   = 3'd2,
    SRC_REDIR = 3'd3,
    SRC_TRAP  = 3'd4
  } pc_src_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// Circular return address stack: push, pop, replace (push+pop) and underflow pulse.
// A full stack overwrites its oldest entry; contents are deliberately not reset.
module pc_ras #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             push_addr_i,
  output logic [WIDTH-1:0]             top_o,
  output logic                         valid_o,
  output logic [$clog2(RAS_DEPTH):0]   count_o,
  output logic                         underflow_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             underflow_q, underflow_d;
  logic             we;
  logic [PW-1:0]    waddr;
  logic             empty;

  assign empty = (count_q == '0);

  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    underflow_d = 1'b0;
    we          = 1'b0;
    waddr       = ptr_q;
    if (pop_i && !empty) begin
      if (push_i) begin
        // Replace: the returning frame's slot is reused by the new call.
        we = 1'b1;
      end else begin
        ptr_d   = ptr_q - 1'b1;
        count_d = count_q - 1'b1;
      end
    end else begin
      underflow_d = pop_i;
      if (push_i) begin
        ptr_d = ptr_q + 1'b1;
        waddr = ptr_q + 1'b1;
        we    = 1'b1;
        if (count_q != CW'(RAS_DEPTH)) count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= push_addr_i;
  end

  assign top_o       = mem_q[ptr_q];
  assign valid_o     = !empty;
  assign count_o     = count_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: trap > redirect > RAS prediction > stall hold > sequential step.
// The return address stack is built only when PC_GEN_RAS_EN is defined.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(DEF_TRAP_VEC),
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       trap,
  input  logic                       redir_valid,
  input  logic [WIDTH-1:0]           redir_target,
  input  logic                       ras_push,
  input  logic [WIDTH-1:0]           ras_push_addr,
  input  logic                       ras_pop,
  output logic [WIDTH-1:0]           pc,
  output logic [WIDTH-1:0]           pc_plus,
  output logic                       redirected,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_underflow
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(STEP - 1));
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             redirected_q, redirected_d;
  pc_src_e          src;
  logic             ras_hit;
  logic [WIDTH-1:0] ras_top;

`ifdef PC_GEN_RAS_EN
  logic ras_gate, ras_push_g, ras_pop_g, ras_valid;

  // Decode-stage stack updates are dropped on a wrong path or when decode will replay.
  assign ras_gate   = !stall && !trap && !redir_valid;
  assign ras_push_g = ras_push && ras_gate;
  assign ras_pop_g  = ras_pop && ras_gate;
  assign ras_hit    = ras_pop_g && ras_valid;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ras_push_g),
    .pop_i       (ras_pop_g),
    .push_addr_i (ras_push_addr & ALIGN_MASK),
    .top_o       (ras_top),
    .valid_o     (ras_valid),
    .count_o     (ras_count),
    .underflow_o (ras_underflow)
  );
`else
  logic unused_ras;

  assign unused_ras    = ^{ras_push, ras_push_addr, ras_pop};
  assign ras_hit       = 1'b0;
  assign ras_top       = '0;
  assign ras_count     = '0;
  assign ras_underflow = 1'b0;
`endif

  always_comb begin
    src = SRC_STEP;
    if (trap)             src = SRC_TRAP;
    else if (redir_valid) src = SRC_REDIR;
    else if (ras_hit)     src = SRC_RAS;
    else if (stall)       src = SRC_HOLD;
  end

  always_comb begin
    pc_d         = pc_q + STEP_W;
    redirected_d = 1'b0;
    unique case (src)
      SRC_TRAP: begin
        pc_d         = TRAP_VEC;
        redirected_d = 1'b1;
      end
      SRC_REDIR: begin
        pc_d         = redir_target & ALIGN_MASK;
        redirected_d = 1'b1;
      end
      SRC_RAS: begin
        pc_d         = ras_top & ALIGN_MASK;
        redirected_d = 1'b1;
      end
      SRC_HOLD: pc_d = pc_q;
      default:  pc_d = pc_q + STEP_W;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_VEC;
      redirected_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      redirected_q <= redirected_d;
    end
  end

  assign pc         = pc_q;
  assign pc_plus    = pc_q + STEP_W;
  assign redirected = redirected_q;

endmodule
